// File: rtl/disp_pkg.sv
// Shared display definitions: value width, digit codes and arbiter state encoding.
// Used by the display arbiter and the 7-segment scanner.
package disp_pkg;

    localparam int DW      = 20;
    localparam int DIGIT_W = 5;

    localparam logic [DW-1:0] BLANK = 20'h0;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_t;

    // 5-bit digit codes understood by the scanner; bit 4 set means no segments lit
    localparam logic [DIGIT_W-1:0] DIG_0     = 5'h00;
    localparam logic [DIGIT_W-1:0] DIG_1     = 5'h01;
    localparam logic [DIGIT_W-1:0] DIG_2     = 5'h02;
    localparam logic [DIGIT_W-1:0] DIG_3     = 5'h03;
    localparam logic [DIGIT_W-1:0] DIG_4     = 5'h04;
    localparam logic [DIGIT_W-1:0] DIG_5     = 5'h05;
    localparam logic [DIGIT_W-1:0] DIG_6     = 5'h06;
    localparam logic [DIGIT_W-1:0] DIG_7     = 5'h07;
    localparam logic [DIGIT_W-1:0] DIG_8     = 5'h08;
    localparam logic [DIGIT_W-1:0] DIG_9     = 5'h09;
    localparam logic [DIGIT_W-1:0] DIG_A     = 5'h0A;
    localparam logic [DIGIT_W-1:0] DIG_B     = 5'h0B;
    localparam logic [DIGIT_W-1:0] DIG_C     = 5'h0C;
    localparam logic [DIGIT_W-1:0] DIG_D     = 5'h0D;
    localparam logic [DIGIT_W-1:0] DIG_E     = 5'h0E;
    localparam logic [DIGIT_W-1:0] DIG_F     = 5'h0F;
    localparam logic [DIGIT_W-1:0] DIG_BLANK = 5'h1F;

    function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first eligible request after index `last`,
// wrapping modulo N, skipping anything set in `exclude`.
module rr_pick
    import disp_pkg::*;
#(
    parameter int N  = 3,
    parameter int LW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [LW-1:0] last,
    input  logic [N-1:0]  exclude,
    output logic [N-1:0]  pick,
    output logic          valid
);

    logic [N-1:0]  cand;
    logic [LW-1:0] sel;
    int            idx;

    assign cand = req & ~exclude;

    always_comb begin
        pick  = '0;
        valid = 1'b0;
        idx   = 0;
        sel   = '0;
        for (int k = 1; k <= N; k++) begin
            idx = int'(last) + k;
            if (idx >= N) idx = idx - N;
            sel = LW'(idx);
            if (!valid && cand[sel]) begin
                pick[sel] = 1'b1;
                valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/disp_arbiter.sv
// Round-robin display value arbiter with minimum dwell per owner.
// Define DISP_ARB_PRIO_EN to make requester 0 pre-empt any other owner.
module disp_arbiter
    import disp_pkg::*;
#(
    parameter int              N_REQ = 3,
    parameter int              DW    = disp_pkg::DW,
    parameter int              DWELL = 50000000,
    parameter logic [DW-1:0]   BLANK = disp_pkg::BLANK
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*DW-1:0] data,
    output logic [N_REQ-1:0]    grant,
    output logic [DW-1:0]       disp_num,
    output logic                busy
);

    localparam int LW = $clog2(N_REQ);
    localparam int CW = $clog2(DWELL + 1);
    localparam logic [CW-1:0] RELOAD = CW'(DWELL - 1);

    arb_state_t       state, state_nxt;
    logic [N_REQ-1:0] grant_nxt;
    logic [N_REQ-1:0] pick;
    logic             pick_valid;
    logic [LW-1:0]    last, last_nxt;
    logic [CW-1:0]    count, count_nxt;
    logic [DW-1:0]    owner_data;
    logic             owner_held;
    logic             take;

    // Excluding the current grant is harmless on release since the owner's req is already low
    rr_pick #(.N(N_REQ), .LW(LW)) u_pick (
        .req     (req),
        .last    (last),
        .exclude (grant),
        .pick    (pick),
        .valid   (pick_valid)
    );

    assign owner_held = |(grant & req);
    assign busy       = |grant;

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        last_nxt  = last;
        count_nxt = (count == '0) ? '0 : count - 1'b1;
        take      = 1'b0;
        case (state)
            IDLE: begin
                if (pick_valid) take = 1'b1;
            end
            HOLD: begin
                if (!owner_held || count == '0) begin
                    if (pick_valid) begin
                        take = 1'b1;
                    end else if (!owner_held) begin
                        grant_nxt = '0;
                        state_nxt = IDLE;
                        count_nxt = '0;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
            end
        endcase
        if (take) begin
            grant_nxt = pick;
            last_nxt  = LW'(onehot_to_idx(8'(pick)));
            count_nxt = RELOAD;
            state_nxt = HOLD;
        end
`ifdef DISP_ARB_PRIO_EN
        if (req[0] && !grant[0]) begin
            grant_nxt    = '0;
            grant_nxt[0] = 1'b1;
            last_nxt     = '0;
            count_nxt    = RELOAD;
            state_nxt    = HOLD;
        end
`else
`endif
    end

    // Value of whoever owned the display during the cycle just ending
    always_comb begin
        owner_data = BLANK;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) owner_data = data[i*DW +: DW];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            grant    <= '0;
            last     <= LW'(N_REQ - 1);
            count    <= '0;
            disp_num <= BLANK;
        end else begin
            state    <= state_nxt;
            grant    <= grant_nxt;
            last     <= last_nxt;
            count    <= count_nxt;
            disp_num <= owner_data;
        end
    end

endmodule

// File: tb/tb_disp_arbiter.sv
// Self-checking bench for disp_arbiter: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against an ownership/age model.
module tb_disp_arbiter;

    localparam int N     = 3;
    localparam int W     = 20;
    localparam int DWELL = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] data;
    logic [N-1:0]   grant;
    logic [W-1:0]   disp_num;
    logic           busy;

    int test_cnt = 0;
    int fail_cnt = 0;
    bit check_en = 1'b0;

    int           m_owner;
    int           m_last;
    int           m_age;
    logic [W-1:0] m_disp;
    int           prev_owner;
    int           p;
    logic [N-1:0] exp_g;

    disp_arbiter #(
        .N_REQ (N),
        .DW    (W),
        .DWELL (DWELL),
        .BLANK (20'h0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .data     (data),
        .grant    (grant),
        .disp_num (disp_num),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // First requester after the last winner, wrapping around, skipping `excl`
    function automatic int find_next(input int excl);
        int c;
        for (int k = 1; k <= N; k++) begin
            c = (m_last + k) % N;
            if (req[c] && c != excl) return c;
        end
        return -1;
    endfunction

    // Model tracks owner index and how many edges it has held the display
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_owner = -1;
            m_last  = N - 1;
            m_age   = 0;
            m_disp  = '0;
        end else begin
            prev_owner = m_owner;
            m_disp     = (prev_owner < 0) ? 20'h0 : data[prev_owner*W +: W];
            p          = -2;
`ifdef DISP_ARB_PRIO_EN
            if (req[0] && m_owner != 0) p = 0;
`endif
            if (p == -2) begin
                if (m_owner < 0) begin
                    p = find_next(-1);
                end else if (!req[m_owner]) begin
                    p = find_next(m_owner);
                    if (p < 0) m_owner = -1;
                end else if (m_age >= DWELL) begin
                    p = find_next(m_owner);
                    if (p < 0) m_age = m_age + 1;
                end else begin
                    p     = -1;
                    m_age = m_age + 1;
                end
            end
            if (p >= 0) begin
                m_owner = p;
                m_last  = p;
                m_age   = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (check_en && !rst) begin
            exp_g = (m_owner < 0) ? '0 : N'(1 << m_owner);
            test_cnt++;
            if (grant !== exp_g || disp_num !== m_disp || busy !== (exp_g != '0)) begin
                fail_cnt++;
                $display("[TB] FAIL model_cmp @%0t: got grant=%b disp=%h busy=%b, expected grant=%b disp=%h busy=%b",
                         $time, grant, disp_num, busy, exp_g, m_disp, (exp_g != '0));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [N-1:0] r);
        req = r;
    endtask

    task automatic checkOutput(input string name, input logic [N-1:0] eg, input logic [W-1:0] ed);
        test_cnt++;
        if (grant !== eg || disp_num !== ed || busy !== (eg != '0)) begin
            fail_cnt++;
            $display("[TB] FAIL %s: got grant=%b disp=%h busy=%b, expected grant=%b disp=%h busy=%b",
                     name, grant, disp_num, busy, eg, ed, (eg != '0));
        end
    endtask

    task automatic resetPulse();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst  = 1'b1;
        req  = '0;
        data = {20'h0F0F0, 20'hABCDE, 20'h12345};
        tick(3);
        rst      = 1'b0;
        check_en = 1'b1;

        tick(10);
        checkOutput("reset_idle", 3'b000, 20'h0);

        applyStimulus(3'b001);
        tick(1);
        checkOutput("single_grant", 3'b001, 20'h0);
        tick(1);
        checkOutput("single_disp", 3'b001, 20'h12345);
        tick(20);
        checkOutput("single_hold", 3'b001, 20'h12345);

        resetPulse();
        applyStimulus(3'b011);
        for (int k = 1; k <= 9; k++) begin
            tick(1);
            checkOutput($sformatf("rotate_%0d", k),
                        (k <= 4) ? 3'b001 : ((k <= 8) ? 3'b010 : 3'b001),
                        (k == 1) ? 20'h0 : ((k <= 5) ? 20'h12345 : 20'hABCDE));
        end

        resetPulse();
        applyStimulus(3'b101);
        tick(2);
        checkOutput("early_owner0", 3'b001, 20'h12345);
        applyStimulus(3'b100);
        tick(1);
        checkOutput("early_release", 3'b100, 20'h12345);
        applyStimulus(3'b101);
        for (int k = 1; k <= 3; k++) begin
            tick(1);
            checkOutput($sformatf("early_dwell_%0d", k), 3'b100, 20'h0F0F0);
        end
        tick(1);
        checkOutput("early_rotate", 3'b001, 20'h0F0F0);
        applyStimulus(3'b000);
        tick(1);
        checkOutput("drop_all", 3'b000, 20'h12345);
        tick(1);
        checkOutput("drop_all_blank", 3'b000, 20'h0);

        applyStimulus(3'b010);
        tick(1);
        checkOutput("async_pre", 3'b010, 20'h0);
        #2 rst = 1'b1;
        #1 checkOutput("async_reset", 3'b000, 20'h0);
        #1 rst = 1'b0;
        applyStimulus(3'b111);
        tick(1);
        checkOutput("async_after", 3'b001, 20'h0);

        applyStimulus(3'b000);
        tick(2);
        applyStimulus(3'b010);
        tick(1);
        checkOutput("prio_owner1", 3'b010, 20'h0);
        applyStimulus(3'b011);
`ifdef DISP_ARB_PRIO_EN
        tick(1);
        checkOutput("prio_preempt", 3'b001, 20'hABCDE);
`else
        tick(3);
        checkOutput("prio_wait", 3'b010, 20'hABCDE);
        tick(1);
        checkOutput("prio_expire", 3'b001, 20'hABCDE);
`endif

        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 99) < 25) req = N'($urandom_range(0, 7));
            if ($urandom_range(0, 99) < 50) data = 60'({$urandom(), $urandom()});
            if ($urandom_range(0, 299) == 0) begin
                #2 rst = 1'b1;
                #1 rst = 1'b0;
            end
        end

        tick(1);
        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/disp_arbiter.md
Name: disp_arbiter

Overview:
- Shares the single 7-segment display value path (20-bit `num` into the display scanner) between up to N_REQ requesters, e.g. the manager and a message/scroll source.
- Grants one requester at a time using round-robin with a minimum dwell time.
- Registers the granted requester's 20-bit value onto `disp_num`.
- Sits between the requesters and the display scanner in the top level.

Parameters:
- N_REQ, 3, number of requesters (2..8).
- DW, 20, display value width (4 digits x 5-bit code).
- DWELL, 50000000, minimum cycles an owner keeps the display while others wait (1 s at 50 MHz); must be >= 1.
- BLANK, 20'h0, value driven when no owner.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous reset, active-high.
- req  input  N_REQ  per-requester display request, level-held while wanted.
- data  input  N_REQ*DW  flattened request values; requester i occupies bits [i*DW +: DW].
- grant  output  N_REQ  one-hot current owner; all-zero when idle.
- disp_num  output  DW  registered value to the display scanner.
- busy  output  1  high when an owner exists (equals |grant).

Behaviour:
- Reset: asynchronous, active-high, immediate, including mid-dwell.
  - grant=0, disp_num=BLANK, busy=0, state=IDLE.
  - Dwell counter = 0.
  - Round-robin pointer last = N_REQ-1, so requester 0 wins first.
- State machine, two states: IDLE and HOLD.
- Round-robin pick: the first requester with req=1 scanning last+1, last+2, … modulo N_REQ. The pick excludes the current owner only when rotating.
- IDLE, on any req=1:
  - Next edge: grant = one-hot(pick), last = pick, counter = DWELL-1, state = HOLD.
- IDLE, no req: stay in IDLE.
- HOLD, counter: decrements by 1 per cycle and saturates at 0.
- HOLD, owner drops req:
  - Release on the next edge.
  - If another req=1: the new pick is granted on the same edge, counter reloads to DWELL-1, state stays HOLD.
  - Otherwise: grant=0, state = IDLE.
- HOLD, owner holds req, counter == 0 and another requester pending:
  - Rotate on the next edge to the pick among the others, counter reloads.
- HOLD, owner holds req and no other requester pending: keep grant indefinitely; the counter stays 0.
- Simultaneous owner-drop and dwell expiry: the release rule applies (identical outcome).
- disp_num latency:
  - Each edge, disp_num <= data slice of the grant held during the preceding cycle, or BLANK if grant=0.
  - So disp_num lags grant by exactly one cycle. A new owner's value appears 2 edges after its req rises from IDLE.
- Owner data changes are tracked every cycle with 1-cycle latency; no data snapshot is taken.
- grant is always one-hot or zero, never multi-hot.
- busy is combinational from the grant register.

Optional Feature:
- Macro: DISP_ARB_PRIO_EN.
- Defined: requester 0 is urgent.
  - If req[0]=1 and the owner != 0, requester 0 is granted on the next edge regardless of the dwell counter. Counter reloads, last = 0.
  - Requester 0 is itself still subject to dwell and rotation.
- Undefined: requester 0 is treated as every other requester under pure round-robin.

Decomposition:
- Shared package `disp_pkg`:
  - DW=20, DIGIT_W=5, BLANK code.
  - State encoding (IDLE=1'b0, HOLD=1'b1).
  - Digit code constants (0-9, A-F, blank) shared with the display scanner.
- One natural sub-module, `rr_pick`:
  - Combinational round-robin selector.
  - Inputs: req vector, last index, exclude-owner mask.
  - Outputs: one-hot pick and a valid flag.
  - Reused by any future button/LED arbitration.

Test Plan (DWELL=4, N_REQ=3, rst pulsed first):
- Reset idle: no req for 10 cycles -> grant=000, disp_num=20'h0, busy=0.
- Single requester: req=001, data0=20'h12345 -> grant=001 after 1 edge, disp_num=20'h12345 after 2 edges. Hold req 20 cycles -> grant stays 001.
- Rotation: req=011 continuously -> grant 001 for 4 cycles, then 010 for 4, then 001. disp_num follows each switch 1 cycle later.
- Early release: req=101 with owner 0; drop req[0] at cycle 2 -> grant=100 on the next edge and the counter reloads (owner 2 held 4 cycles). Drop all -> grant=000, disp_num=20'h0 one cycle later.
- Async reset mid-HOLD: assert rst between edges while grant=010 -> grant=000, disp_num=0 immediately, with no clock edge. After release with req=111 -> grant=001.
- DISP_ARB_PRIO_EN defined: owner 1 at counter 3, raise req[0] -> grant=001 on the next edge. Undefined: the same stimulus waits until dwell expires.
